// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID, register-file, WB and ID/EX signals of the RV32I decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            id_ready;
    logic            flush;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_write_en;
    logic [4:0]      wb_write_addr;
    logic [XLEN-1:0] wb_write_value;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic [4:0]      ex_rd;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic            ex_reg_write;
    logic            ex_is_load;
    logic            ex_illegal;

    modport slave (
        input  if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
               wb_write_en, wb_write_addr, wb_write_value, ex_ready,
        output id_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_opcode, ex_funct3,
               ex_funct7b5, ex_rd, ex_rs1, ex_rs2, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_reg_write, ex_is_load, ex_illegal
    );

    modport master (
        output if_valid, if_pc, if_instr, flush, rs1_data, rs2_data,
               wb_write_en, wb_write_addr, wb_write_value, ex_ready,
        input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_pc, ex_opcode, ex_funct3,
               ex_funct7b5, ex_rd, ex_rs1, ex_rs2, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_reg_write, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage with WB bypass, immediate generation, load-use stall and ID/EX register.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_WB = 1'b1
) (
    input logic          clk,
    input logic          reset,
    decode_stage_if.slave d
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            is_load;
        logic            illegal;
    } idex_t;

    idex_t           idex_q, idex_d, dec;
    logic [31:0]     instr;
    logic [6:0]      opc;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            uses_rs1, uses_rs2, hazard, advance;
    logic            wb_hit1, wb_hit2, hold_hit1, hold_hit2;

    assign instr = d.if_instr;
    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];

    assign d.rs1_addr = rs1;
    assign d.rs2_addr = rs2;

    always_comb begin
        imm_i     = {{20{instr[31]}}, instr[31:20]};
        imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u     = {instr[31:12], 12'b0};
        imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        uses_rs1  = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
        uses_rs2  = opc inside {OP_OP, OP_STORE, OP_BRANCH};
        wb_hit1   = d.wb_write_en && d.wb_write_addr != 5'd0 && d.wb_write_addr == rs1;
        wb_hit2   = d.wb_write_en && d.wb_write_addr != 5'd0 && d.wb_write_addr == rs2;
        hold_hit1 = d.wb_write_en && d.wb_write_addr != 5'd0 && d.wb_write_addr == idex_q.rs1;
        hold_hit2 = d.wb_write_en && d.wb_write_addr != 5'd0 && d.wb_write_addr == idex_q.rs2;
        hazard    = idex_q.valid && idex_q.is_load && idex_q.rd != 5'd0 &&
                    ((uses_rs1 && rs1 == idex_q.rd) || (uses_rs2 && rs2 == idex_q.rd));
        advance   = d.ex_ready || !idex_q.valid;
    end

    always_comb begin
        dec.valid     = d.if_valid;
        dec.pc        = d.if_pc;
        dec.opcode    = opc;
        dec.funct3    = instr[14:12];
        dec.funct7b5  = instr[30];
        dec.rd        = rd;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rs1_val   = (rs1 == 5'd0) ? '0 : (BYPASS_WB && wb_hit1) ? d.wb_write_value : d.rs1_data;
        dec.rs2_val   = (rs2 == 5'd0) ? '0 : (BYPASS_WB && wb_hit2) ? d.wb_write_value : d.rs2_data;
        dec.imm       = (opc inside {OP_LUI, OP_AUIPC}) ? imm_u :
                        (opc == OP_JAL)    ? imm_j :
                        (opc == OP_BRANCH) ? imm_b :
                        (opc == OP_STORE)  ? imm_s :
                        (opc inside {OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM}) ? imm_i : '0;
        dec.reg_write = (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP}) && rd != 5'd0;
        dec.is_load   = opc == OP_LOAD;
        dec.illegal   = !(opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM});
    end

    // A held instruction keeps tracking WB writes so EX never sees stale operands.
    always_comb begin
        idex_d = idex_q;
        if (d.flush || (advance && hazard)) begin
            idex_d.valid = 1'b0;
        end else if (advance) begin
            idex_d = dec;
        end else begin
            idex_d.rs1_val = hold_hit1 ? d.wb_write_value : idex_q.rs1_val;
            idex_d.rs2_val = hold_hit2 ? d.wb_write_value : idex_q.rs2_val;
        end
    end

    always_ff @(posedge clk) begin
        idex_q <= reset ? '0 : idex_d;
    end

    assign d.id_ready     = d.flush || (advance && !hazard);
    assign d.ex_valid     = idex_q.valid;
    assign d.ex_pc        = idex_q.pc;
    assign d.ex_opcode    = idex_q.opcode;
    assign d.ex_funct3    = idex_q.funct3;
    assign d.ex_funct7b5  = idex_q.funct7b5;
    assign d.ex_rd        = idex_q.rd;
    assign d.ex_rs1       = idex_q.rs1;
    assign d.ex_rs2       = idex_q.rs2;
    assign d.ex_rs1_val   = idex_q.rs1_val;
    assign d.ex_rs2_val   = idex_q.rs2_val;
    assign d.ex_imm       = idex_q.imm;
    assign d.ex_reg_write = idex_q.reg_write;
    assign d.ex_is_load   = idex_q.is_load;
    assign d.ex_illegal   = idex_q.illegal;
endmodule
